// File: rtl/reset_pkg.sv
// reset_pkg: shared state encoding, default timing constants and width helper
// for the reset sequencer and its synchronizer.
package reset_pkg;

    typedef enum logic [2:0] {
        S_SYNC,
        S_HOLD,
        S_WAIT,
        S_DONE,
        S_FAIL
    } state_t;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_HOLD        = 16;
    localparam int DEF_TIMEOUT     = 255;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/rst_sync.sv
// rst_sync: async-assert / sync-deassert flop chain; output rises STAGES
// rising edges after rst_n goes high.
module rst_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic o_rst_sync
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_chain <= '0;
        else        r_chain <= (r_chain << 1) | STAGES'(1);
    end

    assign o_rst_sync = r_chain[STAGES-1];

endmodule

// File: rtl/reset_seq.sv
// reset_seq: releases NSTAGES downstream reset domains in order, each after a
// hold period and gated on the previous stage's ready acknowledge.
module reset_seq
    import reset_pkg::*;
#(
    parameter int NSTAGES     = 3,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int HOLD        = DEF_HOLD,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NSTAGES-1:0] ready,
    output logic [NSTAGES-1:0] stage_rst,
    output logic               done,
    output logic               timeout_err,
    output logic [2:0]         cur_stage
);

    localparam int CW = clog2(((HOLD > TIMEOUT) ? HOLD : TIMEOUT) + 1);

    state_t             r_state, w_state;
    logic [CW-1:0]      r_cnt, w_cnt;
    logic [2:0]         r_stage, w_stage;
    logic [NSTAGES-1:0] r_stage_rst, w_stage_rst;
    logic               r_done, w_done;
    logic               r_err, w_err;
    logic               w_sync;
    logic [NSTAGES-1:0] w_sel;
    logic               w_rdy;

    // The FSM leaving SYNC acts as the last synchronizer flop, so the chain
    // here is one shorter and HOLD is entered on the SYNC_STAGES-th edge.
    rst_sync #(.STAGES(SYNC_STAGES - 1)) u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .o_rst_sync (w_sync)
    );

    assign w_sel = NSTAGES'(1) << r_stage;
    assign w_rdy = |(ready & w_sel);

    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_stage     = r_stage;
        w_stage_rst = r_stage_rst;
        w_done      = r_done;
        w_err       = r_err;
        case (r_state)
            S_SYNC: begin
                if (w_sync) begin
                    w_state = S_HOLD;
                    w_cnt   = '0;
                    w_stage = '0;
                end
            end
            S_HOLD: begin
                if (r_cnt == CW'(HOLD - 1)) begin
                    w_stage_rst = r_stage_rst & ~w_sel;
                    w_state     = S_WAIT;
                    w_cnt       = '0;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            S_WAIT: begin
                if (w_rdy && r_stage == 3'(NSTAGES - 1)) begin
                    w_state = S_DONE;
                    w_done  = 1'b1;
                end else if (w_rdy) begin
                    w_stage = r_stage + 3'd1;
                    w_state = S_HOLD;
                    w_cnt   = '0;
                end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                    w_state     = S_FAIL;
                    w_stage_rst = '1;
                    w_err       = 1'b1;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_SYNC;
            r_cnt       <= '0;
            r_stage     <= '0;
            r_stage_rst <= '1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_stage     <= w_stage;
            r_stage_rst <= w_stage_rst;
            r_done      <= w_done;
            r_err       <= w_err;
        end
    end

    assign stage_rst   = r_stage_rst;
    assign done        = r_done;
    assign timeout_err = r_err;
    assign cur_stage   = r_stage;

endmodule

// File: tb/tb_reset_seq.sv
// tb_reset_seq: drives reset/ready scenarios and compares outputs each edge
// against a release/ack schedule computed arithmetically per scenario.
module tb_reset_seq;

    localparam int N   = 3;
    localparam int SS  = 2;
    localparam int HD  = 4;
    localparam int TO  = 8;
    localparam int INF = 1 << 20;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] ready = '0;
    logic [N-1:0] stage_rst;
    logic         done;
    logic         timeout_err;
    logic [2:0]   cur_stage;
    int           checks = 0;
    int           failures = 0;

    always #5 clk = ~clk;

    reset_seq #(.NSTAGES(N), .SYNC_STAGES(SS), .HOLD(HD), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ready       (ready),
        .stage_rst   (stage_rst),
        .done        (done),
        .timeout_err (timeout_err),
        .cur_stage   (cur_stage)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [N-1:0] er, input logic ed,
                            input logic ee, input int ec);
        chk({tag, ".stage_rst"}, 32'(stage_rst), 32'(er));
        chk({tag, ".done"}, 32'(done), 32'(ed));
        chk({tag, ".timeout_err"}, 32'(timeout_err), 32'(ee));
        chk({tag, ".cur_stage"}, 32'(cur_stage), 32'(ec));
    endtask

    // d[s]: edges after release of stage s at which ready[s] is first seen high
    task automatic run_seq(input int d0, input int d1, input int d2, input bit noise,
                           input int abort_e, input int low_cyc, input int tail);
        int d[N];
        int rel[N];
        int ack[N];
        int fail_e, done_e, n, cur, w;
        logic [N-1:0] er;
        logic base;
        d = '{d0, d1, d2};
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_outs("async_rst", '1, 1'b0, 1'b0, 0);
        for (int i = 0; i < low_cyc; i++) begin
            @(posedge clk);
            ready = N'($urandom);
            #1 chk_outs("held_rst", '1, 1'b0, 1'b0, 0);
        end
        rst_n = 1'b1;
        fail_e = INF;
        done_e = INF;
        for (int s = 0; s < N; s++) begin
            rel[s] = INF;
            ack[s] = INF;
        end
        rel[0] = SS + HD;
        for (int s = 0; s < N; s++) begin
            if (rel[s] == INF) break;
            if (d[s] <= TO) begin
                ack[s] = rel[s] + d[s];
                if (s < N - 1) rel[s+1] = ack[s] + HD;
                else done_e = ack[s];
            end else begin
                fail_e = rel[s] + TO;
                break;
            end
        end
        n = ((done_e < fail_e) ? done_e : fail_e) + tail;
        for (int e = 1; e <= n; e++) begin
            @(negedge clk);
            for (int s = 0; s < N; s++) begin
                w = rel[s] + d[s];
                base = (rel[s] != INF) && (e > rel[s]);
                ready[s] = (e <= rel[s] || e > w) ? (noise ? 1'($urandom) : base) : (e == w);
            end
            @(posedge clk);
            #1;
            cur = 0;
            for (int s = 0; s < N; s++) begin
                er[s] = (e < rel[s]) || (e >= fail_e);
                if (ack[s] <= e) cur++;
            end
            if (cur > N - 1) cur = N - 1;
            chk_outs($sformatf("edge%0d", e), er, e >= done_e, e >= fail_e, cur);
            if (e == abort_e) begin
                #2 rst_n = 1'b0;
                #1 chk_outs("abort_rst", '1, 1'b0, 1'b0, 0);
                return;
            end
        end
    endtask

    initial begin
        run_seq(1, 1, 1, 1'b0, 0, 0, 4);
        run_seq(1, 20, 1, 1'b0, 0, 0, 50);
        run_seq(1, 8, 1, 1'b0, 0, 0, 4);
        run_seq(1, 9, 1, 1'b0, 0, 0, 6);
        run_seq(1, 1, 1, 1'b0, 12, 0, 4);
        run_seq(1, 1, 1, 1'b0, 0, 2, 4);
        run_seq(1, 1, 1, 1'b1, 0, 0, 4);
        run_seq(3, 2, 8, 1'b1, 0, 0, 6);
        repeat (25) begin
            int a0, a1, a2, ab, lc, tl;
            a0 = $urandom_range(1, 10);
            a1 = $urandom_range(1, 10);
            a2 = $urandom_range(1, 10);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 30) : 0;
            lc = $urandom_range(0, 2);
            tl = $urandom_range(1, 6);
            run_seq(a0, a1, a2, 1'b1, ab, lc, tl);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
